counter_seq_ctrl: RTL and testbench

- Sequencing controller for a free-running-style binary counter datapath.
- Adds start/stop/pause control, a programmable terminal value, one-shot or auto-reload mode, and a single-cycle terminal pulse.
- Sits between the lab control logic (buttons/FSMs) and the displayed count, replacing a bare always-incrementing counter.

---
 rtl/counter_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a binary count datapath: start/stop/pause, programmable terminal value,
// one-shot or auto-reload runs, one-cycle done pulse. Optional sticky irq via COUNTER_SEQ_IRQ_EN.
module counter_seq_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] limit,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             paused,
    output logic             done,
`ifdef COUNTER_SEQ_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic             r_mode;
    logic             r_done;
    logic             w_at_limit;
`ifdef COUNTER_SEQ_IRQ_EN
    logic             r_irq;
`endif

    assign w_at_limit = (r_count == r_limit);

    // Control FSM: command priority is stop > start > pause > terminal compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= ZERO;
            r_limit <= ZERO;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
`ifdef COUNTER_SEQ_IRQ_EN
            r_irq   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef COUNTER_SEQ_IRQ_EN
            // A terminal event later in this block overrides the clear
            if (irq_clr) begin
                r_irq <= 1'b0;
            end else begin
                r_irq <= r_irq;
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    r_count <= ZERO;
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (start) begin
                        r_limit <= limit;
                        r_mode  <= auto_reload;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_count <= ZERO;
                    end else if (pause) begin
                        r_state <= ST_HOLD;
                    end else if (w_at_limit) begin
                        r_done <= 1'b1;
`ifdef COUNTER_SEQ_IRQ_EN
                        r_irq  <= 1'b1;
`endif
                        if (r_mode) begin
                            r_count <= ZERO;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_count <= r_count + ONE;
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_count <= ZERO;
                    end else if (!pause) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_DONE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_count <= ZERO;
                    end else if (start) begin
                        r_limit <= limit;
                        r_mode  <= auto_reload;
                        r_count <= ZERO;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= ZERO;
                end
            endcase
        end
    end

    assign out    = r_count;
    assign state  = r_state;
    assign busy   = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign paused = (r_state == ST_HOLD);
    assign done   = r_done;
`ifdef COUNTER_SEQ_IRQ_EN
    assign irq    = r_irq;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed scenarios plus randomized commands checked
// against a run-progress reference model (irq checks compiled in with COUNTER_SEQ_IRQ_EN).
module tb_counter_seq_ctrl;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst, start, stop, pause, auto_reload;
    logic [W-1:0] limit;
    logic [W-1:0] out;
    logic         busy, paused, done;
    logic [1:0]   state;
`ifdef COUNTER_SEQ_IRQ_EN
    logic         irq_clr, irq;
`endif

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .limit(limit), .auto_reload(auto_reload), .out(out), .busy(busy),
        .paused(paused), .done(done),
`ifdef COUNTER_SEQ_IRQ_EN
        .irq_clr(irq_clr), .irq(irq),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a run is tracked as the number of counting cycles since it was accepted
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;
    int m_st, m_phase, m_lim;
    bit m_mode, m_done, m_irq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_out();
        if (m_st == M_IDLE) return 0;
        if (m_st == M_DONE) return m_lim;
        if (m_mode) return m_phase % (m_lim + 1);
        return m_phase;
    endfunction

    function automatic void model_reset();
        m_st = M_IDLE; m_phase = 0; m_lim = 0; m_mode = 1'b0; m_done = 1'b0; m_irq = 1'b0;
    endfunction

    function automatic void model_step();
        bit clr;
        m_done = 1'b0;
        if (m_st == M_IDLE || m_st == M_DONE) begin
            if (stop) m_st = M_IDLE;
            else if (start) begin
                m_lim = int'(limit); m_mode = auto_reload; m_phase = 0; m_st = M_RUN;
            end
        end else if (m_st == M_HOLD) begin
            if (stop) m_st = M_IDLE;
            else if (!pause) m_st = M_RUN;
        end else begin
            if (stop) m_st = M_IDLE;
            else if (pause) m_st = M_HOLD;
            else begin
                m_phase++;
                if (m_mode) m_done = (m_phase % (m_lim + 1) == 0);
                else if (m_phase == m_lim + 1) begin
                    m_done = 1'b1; m_st = M_DONE;
                end
            end
        end
        clr = 1'b0;
`ifdef COUNTER_SEQ_IRQ_EN
        clr = irq_clr;
`endif
        m_irq = m_done | (m_irq & ~clr);
    endfunction

    task automatic compare_all();
        chk("out", 32'(out), 32'(exp_out()));
        chk("state", 32'(state), 32'(m_st));
        chk("busy", 32'(busy), 32'(m_st == M_RUN || m_st == M_HOLD));
        chk("paused", 32'(paused), 32'(m_st == M_HOLD));
        chk("done", 32'(done), 32'(m_done));
`ifdef COUNTER_SEQ_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic launch(input int lim, input bit ar);
        start = 1'b1; limit = W'(lim); auto_reload = ar;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_out(input string tag, input int val);
        for (int i = 0; i < 64 && exp_out() != val; i++) tick();
        chk(tag, 32'(out), 32'(val));
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; auto_reload = 1'b0; limit = '0;
`ifdef COUNTER_SEQ_IRQ_EN
        irq_clr = 1'b0;
`endif
        model_reset();
        #2;
        compare_all();
        #6 rst = 1'b0;

        // One-shot limit=3, then auto-reload limit=4 launched from DONE
        launch(3, 1'b0);
        repeat (8) tick();
        chk("oneshot_hold", 32'(out), 32'd3);
        launch(4, 1'b1);
        repeat (16) tick();
        stop = 1'b1; tick(); stop = 1'b0;

        // Pause for three cycles at out=5
        launch(10, 1'b0);
        run_until_out("reach5", 5);
        pause = 1'b1; repeat (3) tick(); pause = 1'b0;
        repeat (12) tick();

        // Stop and start together at out=7; start ignored during RUN
        launch(20, 1'b0);
        run_until_out("reach7", 7);
        stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
        tick();
        launch(6, 1'b0);
        repeat (3) tick();
        start = 1'b1; limit = 5'd2; tick(); start = 1'b0;
        repeat (8) tick();
        chk("no_relatch", 32'(out), 32'd6);

        // Asynchronous reset at out=9, then limit=0 in both modes
        launch(15, 1'b0);
        run_until_out("reach9", 9);
        async_reset();
        launch(0, 1'b0);
        repeat (3) tick();
        launch(0, 1'b1);
        repeat (4) tick();
        stop = 1'b1; tick(); stop = 1'b0;

`ifdef COUNTER_SEQ_IRQ_EN
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        launch(2, 1'b0);
        repeat (5) tick();
        chk("irq_sticky", 32'(irq), 32'd1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        launch(1, 1'b1);
        irq_clr = 1'b1; repeat (4) tick(); irq_clr = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
`endif

        // Randomized command stream
        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom % 4) == 0;
            stop        = ($urandom % 40) == 0;
            pause       = ($urandom % 6) == 0;
            auto_reload = $urandom % 2;
            limit       = ($urandom % 2) ? W'($urandom % 7) : W'($urandom % 32);
`ifdef COUNTER_SEQ_IRQ_EN
            irq_clr     = ($urandom % 8) == 0;
`endif
            if (($urandom % 500) == 0) async_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
